// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one external 8-bit ALU among N_REQ requesters.
// Optional ALU_ARB_ILLEGAL_CHECK_EN: illegal opcodes bypass the ALU and answer with rsp_err.
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  input  logic [3*N_REQ-1:0] req_ctrl,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [7:0]         alu_y,
  input  logic               alu_zero,
  input  logic               alu_negative,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_y,
  output logic [2:0]         rsp_flags,
  output logic               rsp_err,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, grant, op_id;
  logic [7:0] op_a, op_b, y_q;
  logic [2:0] op_ctrl, flags_q;
  logic found, hs, skip, err_q;
  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v % N_REQ);
  endfunction
  // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        grant = wrap(int'(rr_ptr) + k);
      end
  end
  assign hs = !rst && state == IDLE && found;
  assign req_ready = hs ? N_REQ'(1) << grant : '0;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  assign skip = !(req_ctrl[grant*3 +: 3] inside {3'b000, 3'b001, 3'b010, 3'b110});
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = hs ? (skip ? RESP : EXEC) : IDLE;
      EXEC:    state_n = RESP;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      rr_ptr  <= '0;
      op_id   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= '0;
      y_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= wrap(int'(grant) + 1);
        op_id  <= grant;
        err_q  <= skip;
        if (skip) begin
          y_q     <= '0;
          flags_q <= '0;
        end else begin
          op_a    <= req_a[grant*8 +: 8];
          op_b    <= req_b[grant*8 +: 8];
          op_ctrl <= req_ctrl[grant*3 +: 3];
        end
      end
      if (state == EXEC) begin
        y_q     <= alu_y;
        flags_q <= {alu_carry, alu_negative, alu_zero};
      end
    end
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_ctrl  = op_ctrl;
  assign rsp_valid = state == RESP;
  assign rsp_id    = op_id;
  assign rsp_y     = y_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic [3*N-1:0] req_ctrl = '0;
  logic [7:0] alu_a, alu_b, alu_y, rsp_y;
  logic [2:0] alu_ctrl, rsp_flags;
  logic [8:0] sum9;
  logic alu_zero, alu_negative, alu_carry, rsp_valid, rsp_err, busy;
  logic [1:0] rsp_id;
  int total = 0, bad = 0;
  alu_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
    .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );
  always #5 clk = ~clk;
  // External ALU: illegal opcodes return 8'h1F with carry clear.
  assign sum9 = alu_ctrl == 3'b010 ? {1'b0, alu_a} + {1'b0, alu_b} :
                alu_ctrl == 3'b110 ? {1'b0, alu_a} - {1'b0, alu_b} :
                {1'b0, alu_ctrl == 3'b000 ? alu_a & alu_b : alu_ctrl == 3'b001 ? alu_a | alu_b : 8'h1F};
  assign alu_y = sum9[7:0];
  assign alu_carry = sum9[8];
  assign alu_negative = sum9[7];
  assign alu_zero = sum9[7:0] == 8'h00;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_ctrl[i*3 +: 3] = c;
    req_valid[i] = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    tick;
    tick;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if ({rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, busy} !== 16'h0000) begin bad++; $display("FAIL reset_rsp got=%h exp=0000", {rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, busy}); end
    total++; if ({alu_a, alu_b, alu_ctrl} !== 19'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_ctrl}); end
    req_valid = '0;
    rst = 1'b0;
    tick;
  endtask
  task automatic test_single_add;
    rsp_ready = 1'b1;
    drive(0, 8'h05, 8'h03, 3'b010);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL add_grant got=%b exp=0001", req_ready); end
    tick;
    req_valid = '0;
    total++; if ({busy, rsp_valid} !== 2'b10) begin bad++; $display("FAIL add_exec got=%b exp=10", {busy, rsp_valid}); end
    total++; if ({alu_a, alu_b, alu_ctrl} !== {8'h05, 8'h03, 3'b010}) begin bad++; $display("FAIL add_alu got=%h exp=%h", {alu_a, alu_b, alu_ctrl}, {8'h05, 8'h03, 3'b010}); end
    tick;
    total++; if ({rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err} !== {1'b1, 2'd0, 8'h08, 3'b000, 1'b0}) begin bad++; $display("FAIL add_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err}, {1'b1, 2'd0, 8'h08, 3'b000, 1'b0}); end
    tick;
    total++; if ({busy, rsp_valid} !== 2'b00) begin bad++; $display("FAIL add_idle got=%b exp=00", {busy, rsp_valid}); end
  endtask
  task automatic test_sub_underflow;
    drive(2, 8'h03, 8'h05, 3'b110);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL sub_grant got=%b exp=0100", req_ready); end
    tick;
    req_valid = '0;
    tick;
    total++; if ({rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err} !== {1'b1, 2'd2, 8'hFE, 3'b110, 1'b0}) begin bad++; $display("FAIL sub_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err}, {1'b1, 2'd2, 8'hFE, 3'b110, 1'b0}); end
    tick;
  endtask
  task automatic test_round_robin;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int last = -1, g = 0;
    logic [N-1:0] e;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 8'(i + 1), 8'h10, 3'b010);
    for (int cyc = 0; cyc < 40 && g < 5; cyc++) begin
      #1;
      if (req_ready !== '0) begin
        e = N'(1) << exp_id[g];
        total++; if (req_ready !== e) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, e); end
        if (last >= 0) begin
          total++; if (cyc - last !== 3) begin bad++; $display("FAIL rr_interval%0d got=%0d exp=3", g, cyc - last); end
        end
        last = cyc;
        g++;
      end
      tick;
    end
    total++; if (g !== 5) begin bad++; $display("FAIL rr_timeout got=%0d exp=5", g); end
    req_valid = '0;
    tick;
    tick;
    tick;
  endtask
  task automatic test_backpressure;
    rsp_ready = 1'b0;
    drive(1, 8'h80, 8'h80, 3'b010);
    drive(3, 8'h00, 8'h00, 3'b000);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    tick;
    req_valid[1] = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) begin
      total++; if ({rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, busy} !== {1'b1, 2'd1, 8'h00, 3'b101, 1'b0, 1'b1}) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", k, {rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, busy}, {1'b1, 2'd1, 8'h00, 3'b101, 1'b0, 1'b1}); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0000", k, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    total++; if ({busy, rsp_valid} !== 2'b00) begin bad++; $display("FAIL bp_release got=%b exp=00", {busy, rsp_valid}); end
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready); end
    req_valid = '0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_drop got=%b exp=0000", req_ready); end
  endtask
  task automatic test_illegal;
    drive(2, 8'hAA, 8'h00, 3'b011);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL ill_grant got=%b exp=0100", req_ready); end
    tick;
    req_valid = '0;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    total++; if ({rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err} !== {1'b1, 2'd2, 8'h00, 3'b000, 1'b1}) begin bad++; $display("FAIL ill_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err}, {1'b1, 2'd2, 8'h00, 3'b000, 1'b1}); end
    total++; if (alu_a !== 8'h80) begin bad++; $display("FAIL ill_alu_kept got=%h exp=80", alu_a); end
`else
    total++; if ({busy, rsp_valid, alu_a, alu_ctrl} !== {1'b1, 1'b0, 8'hAA, 3'b011}) begin bad++; $display("FAIL ill_exec got=%h exp=%h", {busy, rsp_valid, alu_a, alu_ctrl}, {1'b1, 1'b0, 8'hAA, 3'b011}); end
    tick;
    total++; if ({rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err} !== {1'b1, 2'd2, 8'h1F, 3'b000, 1'b0}) begin bad++; $display("FAIL ill_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err}, {1'b1, 2'd2, 8'h1F, 3'b000, 1'b0}); end
`endif
    tick;
  endtask
  task automatic test_reset_midop;
    int seen = 0;
    drive(3, 8'h01, 8'h01, 3'b010);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rmid_grant got=%b exp=1000", req_ready); end
    tick;
    req_valid = '0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_exec got=%b exp=1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if ({busy, rsp_valid, rsp_y, alu_a} !== 18'h0) begin bad++; $display("FAIL rmid_state got=%h exp=0", {busy, rsp_valid, rsp_y, alu_a}); end
    req_valid = '1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (rsp_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_rsp got=%0d exp=0", seen); end
  endtask
  initial begin
    test_reset;
    test_single_add;
    test_sub_underflow;
    test_round_robin;
    test_backpressure;
    test_illegal;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU among `N_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and control ports from registered copies. It samples the ALU result and flags, then returns them over a response handshake tagged with the requester index. It sits between client blocks and the single `alu` instance; the ALU itself stays combinational and external.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, width of requester index; must be ≥ clog2(`N_REQ`)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  `N_REQ`  per-requester request valid
- `req_ready`  out  `N_REQ`  per-requester accept; one-hot or zero
- `req_a`  in  8*`N_REQ`  operand A; requester i at bits [8i+7:8i]
- `req_b`  in  8*`N_REQ`  operand B, same packing
- `req_ctrl`  in  3*`N_REQ`  opcode; requester i at bits [3i+2:3i]
- `alu_a`, `alu_b`  out  8  operands to ALU
- `alu_ctrl`  out  3  opcode to ALU
- `alu_y`  in  8  ALU result
- `alu_zero`, `alu_negative`, `alu_carry`  in  1  ALU flags
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  `ID_W`  index of the requester that owns the response
- `rsp_y`  out  8  result
- `rsp_flags`  out  3  {carry, negative, zero}
- `rsp_err`  out  1  illegal-opcode indication; see Configuration
- `busy`  out  1  high in any state other than IDLE

## Operation
- Opcode set: 000 AND, 001 OR, 010 ADD, 110 SUB. All other codes are illegal.
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward with modulo-`N_REQ` wrap.
  - `req_ready[grant]` is driven combinationally high only in IDLE.
  - On handshake: capture a/b/ctrl/id into operand registers, set `rr_ptr` = grant+1 mod `N_REQ`, go to EXEC.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_ctrl` are driven from the operand registers.
  - At the end of the cycle, capture `alu_y` and the three flags into the response registers, then go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_id`, `rsp_y`, `rsp_flags` and `rsp_err` are held stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- ALU ports are driven from the operand registers in every state. They change only at capture.
- A requester that drops `req_valid` before being granted is simply skipped. There is no request buffering.
- Responses come back in grant order, one outstanding operation at a time.

## Timing
- Reset:
  - FSM goes to IDLE, `rr_ptr`=0.
  - `req_ready`=0 (combinational from IDLE grant only after reset deasserts), `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_flags`=0, `rsp_err`=0, `busy`=0.
  - `alu_a`=`alu_b`=0, `alu_ctrl`=000.
- Reset mid-operation discards the operation; no response is produced.
- Latency: handshake in cycle T, EXEC in T+1, `rsp_valid` high in T+2.
- Minimum issue interval is 3 cycles, when `rsp_ready` is high in the first RESP cycle. `rsp_ready` stalls extend RESP indefinitely.
- Response accepted in cycle T: IDLE in T+1, and a new grant is possible in T+1.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait. No requester is starved for more than `N_REQ` grants.
- `rr_ptr` wraps from `N_REQ`-1 to 0.

## Configuration
- Macro: `ALU_ARB_ILLEGAL_CHECK_EN`.
- **Defined:**
  - An accepted request with an illegal opcode goes IDLE→RESP directly, skipping EXEC (latency 1 cycle to `rsp_valid`).
  - Response: `rsp_err`=1, `rsp_y`=0, `rsp_flags`=0.
  - ALU ports are not updated for that request.
- **Undefined:**
  - Illegal opcodes pass through EXEC like any other; the response carries whatever the ALU returns (expected `rsp_y`=8'h1F).
  - `rsp_err` is tied to 0.

## Test plan
- Single ADD: requester 0 sends a=8'h05, b=8'h03, ctrl=010, `rsp_ready`=1 → `rsp_valid` 2 cycles after the handshake, `rsp_id`=0, `rsp_y`=8'h08, flags {c,n,z}=000.
- SUB underflow: requester 2 sends a=8'h03, b=8'h05, ctrl=110 → `rsp_y`=8'hFE, carry=1, negative=1, zero=0, `rsp_id`=2.
- Round-robin fairness: all 4 requesters hold valid continuously → grants come in order 0,1,2,3,0.
  - With `rr_ptr`=3 after reset plus three grants, the next grant is 3, then wraps to 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → response fields stable, `req_ready` all 0, `busy`=1; release → IDLE the next cycle.
- Illegal opcode ctrl=011, a=8'hAA:
  - With the macro: `rsp_valid` 1 cycle after the handshake, `rsp_err`=1, `rsp_y`=0.
  - Without the macro: `rsp_y`=8'h1F, `rsp_err`=0.
- Reset mid-op: assert `rst` during EXEC → next cycle IDLE, `rsp_valid`=0, `rr_ptr`=0, and no response is ever issued for the aborted request.
